linetap_buffer: RTL and testbench

Multi-tap line buffer for the Sobel window front end. It accepts one pixel per ready/valid handshake and presents TAPS_P vertically aligned pixels together: the current pixel plus the pixels 1..TAPS_P-1 lines earlier. Line length is a runtime setting of at most MAX_LINE_P. It sits between the pixel source and the 3x3 window/kernel stage and generalises the fixed two-tap RAM delay buffer in three ways: N taps, runtime line length, and fill tracking.

---
 rtl/linetap_pkg.sv | 17 +
 rtl/linetap_buffer_sdp_ram.sv | 31 +++
 rtl/linetap_buffer.sv | 140 ++++++++++++++
 tb/tb_linetap_buffer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/linetap_pkg.sv
// Shared helpers for the multi-tap line buffer: range clamp and tap-field indexing.
package linetap_pkg;

    function automatic int unsigned clamp_u(input int unsigned v,
                                            input int unsigned lo,
                                            input int unsigned hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Bit offset of field k in a word built from w-bit pixel fields.
    function automatic int unsigned tap_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/linetap_buffer_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with read enable.
module sdp_ram #(
    parameter int WIDTH_P  = 8,
    parameter int DEPTH_P  = 640,
    parameter int ADDR_W_P = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [ADDR_W_P-1:0] waddr_i,
    input  logic [WIDTH_P-1:0]  wdata_i,
    input  logic                re_i,
    input  logic [ADDR_W_P-1:0] raddr_i,
    output logic [WIDTH_P-1:0]  rdata_o
);

    logic [WIDTH_P-1:0] r_mem [DEPTH_P];
    logic [WIDTH_P-1:0] r_rdata;

    // NOTE: storage has no reset so it maps onto block RAM; readers must mask unwritten words.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            r_rdata <= r_mem[raddr_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/linetap_buffer.sv
// Multi-tap line buffer: presents TAPS_P vertically aligned pixels per accepted input,
// with runtime line length and per-tap fill tracking.
module linetap_buffer
    import linetap_pkg::*;
#(
    parameter int WIDTH_P    = 8,
    parameter int MAX_LINE_P = 640,
    parameter int TAPS_P     = 3,
    parameter int LEN_W_P    = $clog2(MAX_LINE_P + 1)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        cfg_i,
    input  logic [LEN_W_P-1:0]          line_len_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [WIDTH_P-1:0]          data_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [TAPS_P*WIDTH_P-1:0]   data_o,
    output logic [TAPS_P-1:0]           tap_valid_o,
    output logic                        primed_o
);

    localparam int LEN_W  = $clog2(MAX_LINE_P + 1);
    localparam int ADDR_W = (MAX_LINE_P > 1) ? $clog2(MAX_LINE_P) : 1;
    localparam int WORD_W = (TAPS_P - 1) * WIDTH_P;
    localparam int FILL_W = $clog2((TAPS_P - 1) * MAX_LINE_P + 1);

    logic                 w_acc;
    logic                 w_take;
    logic                 w_ptr_last;
    logic [FILL_W-1:0]    w_fill_max;
    logic [TAPS_P-1:0]    w_fill_valid;
    logic [WORD_W-1:0]    w_rd_word;
    logic [WORD_W-1:0]    w_wb_word;

    logic [LEN_W-1:0]     r_len;
    logic [ADDR_W-1:0]    r_ptr;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_wb_pend;
    logic [ADDR_W-1:0]    r_wb_addr;
    logic [WIDTH_P-1:0]   r_wb_data;
    logic                 r_valid;
    logic [WIDTH_P-1:0]   r_tap0;
    logic [TAPS_P-1:0]    r_tap_valid;

    assign ready_o = ~r_valid | ready_i;
    assign w_acc   = valid_i & ready_o;
    // A soft restart wins over a same-cycle accept; that pixel is dropped.
    assign w_take  = w_acc & ~cfg_i;

    assign w_ptr_last = (LEN_W'(r_ptr) == (r_len - LEN_W'(1)));
    assign w_fill_max = FILL_W'(TAPS_P - 1) * FILL_W'(r_len);

    assign w_fill_valid[0] = 1'b1;
    for (genvar k = 1; k < TAPS_P; k++) begin : g_fill_valid
        assign w_fill_valid[k] = (r_fill >= FILL_W'(k) * FILL_W'(r_len));
    end

    // Writeback shifts every stored line up one field and inserts the new pixel at field 0.
    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    always_comb begin
        w_wb_word = w_rd_word;
        w_wb_word[0 +: WIDTH_P] = r_wb_data;
        for (int j = 1; j < TAPS_P - 1; j++) begin
            w_wb_word[tap_lsb(j, WIDTH_P) +: WIDTH_P] = w_rd_word[tap_lsb(j - 1, WIDTH_P) +: WIDTH_P];
        end
    end

    sdp_ram #(
        .WIDTH_P  (WORD_W),
        .DEPTH_P  (MAX_LINE_P),
        .ADDR_W_P (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (r_wb_pend),
        .waddr_i (r_wb_addr),
        .wdata_i (w_wb_word),
        .re_i    (w_take),
        .raddr_i (r_ptr),
        .rdata_o (w_rd_word)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_len       <= LEN_W'(MAX_LINE_P);
            r_ptr       <= '0;
            r_fill      <= '0;
            r_wb_pend   <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_valid     <= 1'b0;
            r_tap0      <= '0;
            r_tap_valid <= '0;
        end else if (cfg_i) begin
            r_len       <= LEN_W'(clamp_u(32'(line_len_i), 2, MAX_LINE_P));
            r_ptr       <= '0;
            r_fill      <= '0;
            r_wb_pend   <= 1'b0;
            r_valid     <= 1'b0;
            r_tap0      <= '0;
            r_tap_valid <= '0;
        end else begin
            r_wb_pend <= w_take;
            if (w_take) begin
                r_wb_addr   <= r_ptr;
                r_wb_data   <= data_i;
                r_ptr       <= w_ptr_last ? '0 : r_ptr + ADDR_W'(1);
                if (r_fill < w_fill_max) begin
                    r_fill <= r_fill + FILL_W'(1);
                end
                r_tap0      <= data_i;
                r_tap_valid <= w_fill_valid;
                r_valid     <= 1'b1;
            end else if (ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Taps whose line has not been filled yet read as zero, hiding stale RAM contents.
    always_comb begin
        data_o = '0;
        if (r_tap_valid[0]) begin
            data_o[0 +: WIDTH_P] = r_tap0;
        end
        for (int k = 1; k < TAPS_P; k++) begin
            if (r_tap_valid[k]) begin
                data_o[tap_lsb(k, WIDTH_P) +: WIDTH_P] = w_rd_word[tap_lsb(k - 1, WIDTH_P) +: WIDTH_P];
            end
        end
    end

    assign valid_o     = r_valid;
    assign tap_valid_o = r_tap_valid;
    assign primed_o    = &r_tap_valid;

endmodule

// File: tb/tb_linetap_buffer.sv
// Scoreboard bench for linetap_buffer: directed streams, expected taps queued on accept.
module tb_linetap_buffer;

    localparam int W    = 8;
    localparam int MAXL = 640;
    localparam int TAPS = 3;
    localparam int LW   = $clog2(MAXL + 1);

    typedef struct {
        logic [TAPS*W-1:0] data;
        logic [TAPS-1:0]   tv;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rstn_i = 1'b0;
    logic              cfg_i = 1'b0;
    logic [LW-1:0]     line_len_i;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [W-1:0]      data_i;
    logic              valid_o;
    logic              ready_i;
    logic [TAPS*W-1:0] data_o;
    logic [TAPS-1:0]   tap_valid_o;
    logic              primed_o;

    logic rand_ready = 1'b0;
    logic ready_set  = 1'b1;
    logic rnd_bit    = 1'b1;
    assign ready_i = rand_ready ? rnd_bit : ready_set;

    exp_t       sb[$];
    logic [7:0] hist[$];
    int         model_len = MAXL;
    int         test_id   = 0;
    int         checks    = 0;
    int         failures  = 0;

    linetap_buffer #(
        .WIDTH_P    (W),
        .MAX_LINE_P (MAXL),
        .TAPS_P     (TAPS),
        .LEN_W_P    (LW)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .cfg_i       (cfg_i),
        .line_len_i  (line_len_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .tap_valid_o (tap_valid_o),
        .primed_o    (primed_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s (test %0d): got=%0h expected=%0h", name, test_id, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            rnd_bit = 1'($urandom_range(1));
        end
    end

    // Monitor: compare whenever the downstream handshake completes at the next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rstn_i && valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_output (test %0d): got data=%0h with no pending expectation", test_id, data_o);
                end else begin
                    e = sb.pop_front();
                    check("data", 64'(data_o), 64'(e.data));
                    check("tap_valid", 64'(tap_valid_o), 64'(e.tv));
                    check("primed", 64'(primed_o), 64'(&e.tv));
                    if (test_id == 1 && data_o[7:0] == 8'd8) begin
                        check("t1_in8_taps", 64'(data_o), 64'h000408);
                        check("t1_in8_tap_valid", 64'(tap_valid_o), 64'b111);
                        check("t1_in8_primed", 64'(primed_o), 64'd1);
                    end
                    if (test_id == 1 && data_o[7:0] == 8'd5) begin
                        check("t1_in5_tap_valid", 64'(tap_valid_o), 64'b011);
                        check("t1_in5_tap2", 64'(data_o[23:16]), 64'd0);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic push_expected(input logic [7:0] pv);
        exp_t e;
        int n;
        n = hist.size();
        hist.push_back(pv);
        e.data = '0;
        e.tv   = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (n >= k * model_len) begin
                e.tv[k] = 1'b1;
                e.data[k*W +: W] = hist[n - k * model_len];
            end
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic drive_pixel(input logic [7:0] pv);
        int guard;
        guard = 0;
        valid_i = 1'b1;
        data_i  = pv;
        forever begin
            @(negedge clk_i);
            if (ready_o) begin
                push_expected(pv);
                break;
            end
            guard++;
            if (guard > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout (test %0d): pixel %0h never accepted", test_id, pv);
                break;
            end
            @(posedge clk_i);
            #1;
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic stream(input int n, input int off, input int mult, input int vpct);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 6 && vpct < 100 && $urandom_range(99) >= vpct; g++) begin
                idle(1);
            end
            drive_pixel(8'((i * mult + off) & 255));
        end
    endtask

    task automatic do_cfg(input logic [LW-1:0] val, input int exp_len, input bit with_pixel);
        cfg_i      = 1'b1;
        line_len_i = val;
        valid_i    = with_pixel;
        data_i     = 8'hAA;
        @(posedge clk_i);
        #1;
        cfg_i   = 1'b0;
        valid_i = 1'b0;
        hist.delete();
        model_len = exp_len;
    endtask

    initial begin
        line_len_i = '0;
        data_i     = '0;
        #12;
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_data_o", 64'(data_o), 64'd0);
        check("rst_tap_valid_o", 64'(tap_valid_o), 64'd0);
        check("rst_primed_o", 64'(primed_o), 64'd0);
        check("rst_ready_o", 64'(ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        test_id = 1;
        do_cfg(LW'(4), 4, 1'b0);
        stream(16, 0, 1, 100);
        idle(4);

        test_id = 2;
        do_cfg(LW'(5), 5, 1'b0);
        rand_ready = 1'b1;
        stream(200, 37, 3, 70);
        rand_ready = 1'b0;
        idle(4);

        test_id = 3;
        do_cfg(LW'(2), 2, 1'b0);
        stream(30, 11, 5, 100);
        idle(4);

        test_id = 4;
        do_cfg(LW'(0), 2, 1'b0);
        stream(12, 200, 7, 100);
        idle(4);

        test_id = 5;
        do_cfg(LW'(3), 3, 1'b0);
        stream(10, 90, 1, 100);
        do_cfg(LW'(3), 3, 1'b1);
        @(negedge clk_i);
        check("cfg_drop_valid_o", 64'(valid_o), 64'd0);
        check("cfg_drop_tap_valid", 64'(tap_valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        stream(9, 150, 1, 100);
        idle(4);

        test_id = 6;
        do_cfg(LW'(3), 3, 1'b0);
        stream(7, 60, 1, 100);
        ready_set = 1'b0;
        idle(3);
        check("stall_valid_o", 64'(valid_o), 64'd1);
        check("stall_ready_o", 64'(ready_o), 64'd0);
        check("stall_primed_o", 64'(primed_o), 64'd1);
        #2;
        rstn_i = 1'b0;
        #1;
        check("arst_valid_o", 64'(valid_o), 64'd0);
        check("arst_data_o", 64'(data_o), 64'd0);
        check("arst_primed_o", 64'(primed_o), 64'd0);
        check("arst_tap_valid_o", 64'(tap_valid_o), 64'd0);
        check("arst_ready_o", 64'(ready_o), 64'd1);
        sb.delete();
        hist.delete();
        model_len = MAXL;
        @(posedge clk_i);
        #1;
        rstn_i    = 1'b1;
        ready_set = 1'b1;
        @(posedge clk_i);
        #1;

        test_id = 7;
        stream(700, 3, 1, 100);
        idle(4);

        test_id = 8;
        do_cfg(LW'(1000), 640, 1'b0);
        stream(1290, 5, 1, 100);
        idle(4);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
